fetch_queue: RTL and testbench

Parametrised instruction-fetch front end that replaces the single-entry IF→ID register with a DEPTH-entry prefetch queue. It owns the fetch PC, issues sequential requests to instruction memory over a req/ack handshake, and buffers {pc, pc+4, inst} entries for the ID stage. It handles redirects (branch, trap, xRET) by flushing, including the discard of an in-flight request.

---
 rtl/dataflow_pkg.sv | 19 +
 rtl/fetch_queue_fifo.sv | 53 +++++
 rtl/fetch_queue.sv | 152 +++++++++++++++
 tb/tb_fetch_queue.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dataflow_pkg.sv
// Shared types for the instruction-fetch front end: queue entry layout and fetch FSM states.
package dataflow_pkg;

    // Entry fields are sized for the widest supported PC; narrower builds use the low bits.
    localparam int FETCH_XLEN = 64;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] pc_plus_4;
        logic [31:0]           inst;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        FetchIdle,
        FetchReq,
        FetchDrop
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// DEPTH-entry circular buffer of fetch entries; clear empties it without touching storage.
module fetch_fifo
    import dataflow_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  fetch_entry_t                 wr_entry,
    output fetch_entry_t                 rd_entry,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    fetch_entry_t     mem [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: ;
            endcase
        end
    end

    assign rd_entry = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Prefetching instruction-fetch front end: owns fetch_pc, requests memory, queues entries for ID.
// Optional FETCH_QUEUE_BYPASS_EN: empty-queue acks drive the ID outputs in the ack cycle.
//
// state     | meaning
// FetchIdle | no request outstanding
// FetchReq  | request for fetch_pc outstanding
// FetchDrop | request in flight whose response will be discarded
module fetch_queue
    import dataflow_pkg::*;
#(
    parameter int                   DATA_SIZE = 32,
    parameter int                   DEPTH     = 4,
    parameter logic [DATA_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         redirect,
    input  logic [DATA_SIZE-1:0]         redirect_pc,
    output logic                         inst_mem_req,
    output logic [DATA_SIZE-1:0]         inst_mem_addr,
    input  logic                         inst_mem_ack,
    input  logic [31:0]                  inst_mem_data,
    input  logic                         id_ready,
    output logic                         inst_valid,
    output logic [31:0]                  inst_out,
    output logic [DATA_SIZE-1:0]         pc_out,
    output logic [DATA_SIZE-1:0]         pc_plus_4_out,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    fetch_state_t         state_q;
    fetch_state_t         state_next;
    logic [DATA_SIZE-1:0] fetch_pc_q;
    logic [DATA_SIZE-1:0] fetch_pc_next;
    logic [DATA_SIZE-1:0] req_addr_q;
    logic [DATA_SIZE-1:0] redirect_target;

    logic                 ack_accept;
    logic                 bypass_hit;
    logic                 bypass_take;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic [OCC_W-1:0]     fifo_occ;
    logic [OCC_W-1:0]     occ_after;
    fetch_entry_t         wr_entry;
    fetch_entry_t         head;
    logic                 unused_bits;

    assign redirect_target = {redirect_pc[DATA_SIZE-1:2], 2'b00};
    assign ack_accept      = (state_q == FetchReq) && inst_mem_ack && !redirect;
    assign fifo_empty      = (fifo_occ == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_hit  = fifo_empty && ack_accept;
    assign bypass_take = bypass_hit && id_ready;
`else
    assign bypass_hit  = 1'b0;
    assign bypass_take = 1'b0;
`endif

    assign push      = ack_accept && !bypass_take;
    assign pop       = !fifo_empty && id_ready && !redirect;
    assign occ_after = fifo_occ + OCC_W'(push) - OCC_W'(pop);

    assign wr_entry.pc        = FETCH_XLEN'(fetch_pc_q);
    assign wr_entry.pc_plus_4 = FETCH_XLEN'(fetch_pc_q + DATA_SIZE'(4));
    assign wr_entry.inst      = inst_mem_data;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (redirect),
        .push      (push),
        .pop       (pop),
        .wr_entry  (wr_entry),
        .rd_entry  (head),
        .occupancy (fifo_occ)
    );

    // The request address is frozen while a discarded request is still in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= FetchIdle;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_next;
            fetch_pc_q <= fetch_pc_next;
            if (state_next != FetchDrop) begin
                req_addr_q <= fetch_pc_next;
            end
        end
    end

    always_comb begin
        state_next    = state_q;
        fetch_pc_next = fetch_pc_q;
        if (redirect) begin
            fetch_pc_next = redirect_target;
            case (state_q)
                FetchIdle: state_next = FetchReq;
                FetchReq:  state_next = inst_mem_ack ? FetchReq : FetchDrop;
                FetchDrop: state_next = inst_mem_ack ? FetchReq : FetchDrop;
                default:   state_next = FetchIdle;
            endcase
        end else begin
            case (state_q)
                FetchIdle: begin
                    if (fifo_occ < OCC_W'(DEPTH)) begin
                        state_next = FetchReq;
                    end
                end
                FetchReq: begin
                    if (inst_mem_ack) begin
                        fetch_pc_next = fetch_pc_q + DATA_SIZE'(4);
                        state_next    = (occ_after < OCC_W'(DEPTH)) ? FetchReq : FetchIdle;
                    end
                end
                FetchDrop: begin
                    if (inst_mem_ack) begin
                        state_next = FetchReq;
                    end
                end
                default: state_next = FetchIdle;
            endcase
        end
    end

    always_comb begin
        inst_mem_req  = (state_q != FetchIdle);
        inst_mem_addr = req_addr_q;
        occupancy     = fifo_occ;
        inst_valid    = !fifo_empty && !redirect;
        inst_out      = head.inst;
        pc_out        = head.pc[DATA_SIZE-1:0];
        pc_plus_4_out = head.pc_plus_4[DATA_SIZE-1:0];
        if (bypass_hit) begin
            inst_valid    = 1'b1;
            inst_out      = inst_mem_data;
            pc_out        = fetch_pc_q;
            pc_plus_4_out = fetch_pc_q + DATA_SIZE'(4);
        end
    end

    assign unused_bits = ^{head.pc, head.pc_plus_4, redirect_pc[1:0]};

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (default build, DEPTH=4, 32-bit PC, RESET_PC=0).
module tb_fetch_queue;

    localparam int DATA_SIZE = 32;
    localparam int DEPTH     = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_mem_req;
    logic [31:0] inst_mem_addr;
    logic        inst_mem_ack = 1'b0;
    logic [31:0] inst_mem_data = '0;
    logic        id_ready = 1'b0;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus_4_out;
    logic [2:0]  occupancy;

    int n_checks = 0;
    int n_fail   = 0;
    int mem_lat  = 0;
    bit mem_en   = 1'b0;
    int wait_cnt = 0;

    fetch_queue #(
        .DATA_SIZE (DATA_SIZE),
        .DEPTH     (DEPTH),
        .RESET_PC  (32'h0)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .inst_mem_req  (inst_mem_req),
        .inst_mem_addr (inst_mem_addr),
        .inst_mem_ack  (inst_mem_ack),
        .inst_mem_data (inst_mem_data),
        .id_ready      (id_ready),
        .inst_valid    (inst_valid),
        .inst_out      (inst_out),
        .pc_out        (pc_out),
        .pc_plus_4_out (pc_plus_4_out),
        .occupancy     (occupancy)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    // Memory model: acks a request after mem_lat idle cycles; runs 2ns after negedge.
    always begin
        @(negedge clock);
        #2;
        if (!mem_en || !inst_mem_req) begin
            inst_mem_ack = 1'b0;
            wait_cnt     = 0;
        end else if (wait_cnt >= mem_lat) begin
            inst_mem_ack  = 1'b1;
            inst_mem_data = mem_word(inst_mem_addr);
            wait_cnt      = 0;
        end else begin
            inst_mem_ack = 1'b0;
            wait_cnt     = wait_cnt + 1;
        end
    end

    task automatic do_reset();
        reset    = 1'b1;
        mem_en   = 1'b0;
        redirect = 1'b0;
        id_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++; if (inst_mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %0b want 0", inst_mem_req); end
        n_checks++; if (inst_mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", inst_mem_addr); end
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", inst_valid); end
        n_checks++; if (inst_out !== 32'h0) begin n_fail++; $display("FAIL reset_inst got %h want 0", inst_out); end
        n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", pc_out); end
        n_checks++; if (pc_plus_4_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc4 got %h want 0", pc_plus_4_out); end
        n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        mem_en = 1'b1; mem_lat = 0; id_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            n_checks++; if (inst_mem_req !== 1'b1) begin n_fail++; $display("FAIL b2b_req k=%0d got %0b want 1", k, inst_mem_req); end
            n_checks++; if (inst_mem_addr !== 32'(4*k)) begin n_fail++; $display("FAIL b2b_addr k=%0d got %h want %h", k, inst_mem_addr, 32'(4*k)); end
            if (k == 0) begin
                n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid0 got %0b want 0", inst_valid); end
            end else begin
                n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid k=%0d got %0b want 1", k, inst_valid); end
                n_checks++; if (pc_out !== 32'(4*(k-1))) begin n_fail++; $display("FAIL b2b_pc k=%0d got %h want %h", k, pc_out, 32'(4*(k-1))); end
                n_checks++; if (pc_plus_4_out !== 32'(4*k)) begin n_fail++; $display("FAIL b2b_pc4 k=%0d got %h want %h", k, pc_plus_4_out, 32'(4*k)); end
                n_checks++; if (inst_out !== mem_word(32'(4*(k-1)))) begin n_fail++; $display("FAIL b2b_inst k=%0d got %h want %h", k, inst_out, mem_word(32'(4*(k-1)))); end
            end
        end
    endtask

    task automatic test_fill_stall();
        int i;
        do_reset();
        mem_en = 1'b1; mem_lat = 0; id_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            n_checks++; if (occupancy !== 3'(k)) begin n_fail++; $display("FAIL fill_occ k=%0d got %0d want %0d", k, occupancy, k); end
            n_checks++; if (inst_mem_addr !== 32'(4*k)) begin n_fail++; $display("FAIL fill_addr k=%0d got %h want %h", k, inst_mem_addr, 32'(4*k)); end
        end
        @(negedge clock);
        n_checks++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL full_occ got %0d want 4", occupancy); end
        n_checks++; if (inst_mem_req !== 1'b0) begin n_fail++; $display("FAIL full_req got %0b want 0", inst_mem_req); end
        n_checks++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL full_head got %h want 0", pc_out); end
        id_ready = 1'b1;
        @(negedge clock);
        id_ready = 1'b0;
        n_checks++; if (occupancy !== 3'd3) begin n_fail++; $display("FAIL pop1_occ got %0d want 3", occupancy); end
        n_checks++; if (pc_out !== 32'h4) begin n_fail++; $display("FAIL pop1_head got %h want 4", pc_out); end
        i = 0;
        while (!inst_mem_req && i < 5) begin
            @(negedge clock);
            i++;
        end
        n_checks++; if (inst_mem_req !== 1'b1) begin n_fail++; $display("FAIL resume_req got %0b want 1 (timeout)", inst_mem_req); end
        n_checks++; if (inst_mem_addr !== 32'h10) begin n_fail++; $display("FAIL resume_addr got %h want 10", inst_mem_addr); end
    endtask

    task automatic test_redirect_drop();
        int i;
        do_reset();
        mem_en = 1'b1; mem_lat = 3; id_ready = 1'b1;
        @(negedge clock);
        n_checks++; if (inst_mem_req !== 1'b1 || inst_mem_addr !== 32'h0) begin n_fail++; $display("FAIL drop_first_req got req=%0b addr=%h want 1/0", inst_mem_req, inst_mem_addr); end
        @(negedge clock);
        redirect = 1'b1; redirect_pc = 32'h200;
        @(negedge clock);
        redirect = 1'b0;
        n_checks++; if (inst_mem_req !== 1'b1 || inst_mem_addr !== 32'h0) begin n_fail++; $display("FAIL drop_hold1 got req=%0b addr=%h want 1/0", inst_mem_req, inst_mem_addr); end
        @(negedge clock);
        n_checks++; if (inst_mem_req !== 1'b1 || inst_mem_addr !== 32'h0) begin n_fail++; $display("FAIL drop_hold2 got req=%0b addr=%h want 1/0", inst_mem_req, inst_mem_addr); end
        @(negedge clock);
        n_checks++; if (inst_mem_addr !== 32'h200) begin n_fail++; $display("FAIL drop_newaddr got %h want 200", inst_mem_addr); end
        n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL drop_discard_occ got %0d want 0", occupancy); end
        i = 0;
        while (!inst_valid && i < 10) begin
            @(negedge clock);
            i++;
        end
        n_checks++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL drop_valid got %0b want 1 (timeout)", inst_valid); end
        n_checks++; if (pc_out !== 32'h200) begin n_fail++; $display("FAIL drop_pc got %h want 200", pc_out); end
        n_checks++; if (pc_plus_4_out !== 32'h204) begin n_fail++; $display("FAIL drop_pc4 got %h want 204", pc_plus_4_out); end
        n_checks++; if (inst_out !== mem_word(32'h200)) begin n_fail++; $display("FAIL drop_inst got %h want %h", inst_out, mem_word(32'h200)); end
    endtask

    task automatic test_redirect_with_ack();
        do_reset();
        mem_en = 1'b1; mem_lat = 0; id_ready = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++; if (occupancy !== 3'd2) begin n_fail++; $display("FAIL rda_pre_occ got %0d want 2", occupancy); end
        n_checks++; if (inst_mem_addr !== 32'h8) begin n_fail++; $display("FAIL rda_pre_addr got %h want 8", inst_mem_addr); end
        redirect = 1'b1; redirect_pc = 32'h403; id_ready = 1'b1;
        #3;
        n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rda_forced_valid got %0b want 0", inst_valid); end
        @(negedge clock);
        redirect = 1'b0; id_ready = 1'b0;
        n_checks++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rda_occ got %0d want 0", occupancy); end
        n_checks++; if (inst_mem_req !== 1'b1) begin n_fail++; $display("FAIL rda_req got %0b want 1", inst_mem_req); end
        n_checks++; if (inst_mem_addr !== 32'h400) begin n_fail++; $display("FAIL rda_addr got %h want 400", inst_mem_addr); end
        @(negedge clock);
        n_checks++; if (inst_valid !== 1'b1 || pc_out !== 32'h400) begin n_fail++; $display("FAIL rda_head got valid=%0b pc=%h want 1/400", inst_valid, pc_out); end
        n_checks++; if (occupancy !== 3'd1) begin n_fail++; $display("FAIL rda_occ1 got %0d want 1", occupancy); end
    endtask

    task automatic test_wrap_steady();
        do_reset();
        mem_en = 1'b1; mem_lat = 0; id_ready = 1'b0;
        repeat (4) @(negedge clock);
        for (int i = 0; i <= 2*DEPTH; i++) begin
            if (i > 0) @(negedge clock);
            n_checks++; if (occupancy !== 3'd3) begin n_fail++; $display("FAIL wrap_occ i=%0d got %0d want 3", i, occupancy); end
            n_checks++; if (pc_out !== 32'(4*i)) begin n_fail++; $display("FAIL wrap_pc i=%0d got %h want %h", i, pc_out, 32'(4*i)); end
            n_checks++; if (inst_out !== mem_word(32'(4*i))) begin n_fail++; $display("FAIL wrap_inst i=%0d got %h want %h", i, inst_out, mem_word(32'(4*i))); end
            id_ready = 1'b1;
        end
        id_ready = 1'b0;
    endtask

    task automatic test_reset_mid_request();
        do_reset();
        mem_en = 1'b1; mem_lat = 0; id_ready = 1'b0;
        repeat (3) @(negedge clock);
        mem_en = 1'b0;
        @(negedge clock);
        n_checks++; if (inst_mem_req !== 1'b1 || inst_mem_addr !== 32'h8) begin n_fail++; $display("FAIL mid_req got req=%0b addr=%h want 1/8", inst_mem_req, inst_mem_addr); end
        n_checks++; if (occupancy !== 3'd2) begin n_fail++; $display("FAIL mid_occ got %0d want 2", occupancy); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_checks++; if (inst_mem_req !== 1'b0 || inst_mem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_rst_req got req=%0b addr=%h want 0/0", inst_mem_req, inst_mem_addr); end
        n_checks++; if (inst_valid !== 1'b0 || occupancy !== 3'd0) begin n_fail++; $display("FAIL mid_rst_q got valid=%0b occ=%0d want 0/0", inst_valid, occupancy); end
        n_checks++; if (inst_out !== 32'h0 || pc_out !== 32'h0 || pc_plus_4_out !== 32'h0) begin n_fail++; $display("FAIL mid_rst_out got inst=%h pc=%h pc4=%h want 0", inst_out, pc_out, pc_plus_4_out); end
        mem_en = 1'b1;
        @(negedge clock);
        n_checks++; if (inst_mem_req !== 1'b1 || inst_mem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_restart got req=%0b addr=%h want 1/0", inst_mem_req, inst_mem_addr); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_fill_stall();
        test_redirect_drop();
        test_redirect_with_ack();
        test_wrap_steady();
        test_reset_mid_request();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
